fifo_pack_reader: RTL and testbench

//  Downstream drain stage for the WIDTH-bit synchronous FIFO. Pops words through the FIFO read

---
 rtl/fifo_pack_reader.sv | 115 +++++++++++
 tb/tb_fifo_pack_reader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pack_reader.sv
// fifo_pack_reader: drains a WIDTH-bit synchronous FIFO and packs RATIO words per output beat.
// Latency: 1 cycle read-to-capture; a full beat is presented 1 cycle after its last capture.
// Backpressure: out_valid/out_ready; a held beat stalls assembly at RATIO words and stops FIFO reads.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   fifo_empty, fifo_data_in  FIFO status and registered read data (valid the cycle after a pop)
//   fifo_read                 pop request, combinational from state and fifo_empty
//   flush, flush_done         close the current (possibly partial) beat / completion pulse
//   out_valid, out_ready      output beat handshake
//   out_data, out_count       packed beat (first word in the low lanes) and number of valid words
module fifo_pack_reader #(
   parameter  int WIDTH = 16,
   parameter  int RATIO = 4,
   localparam int CW    = $clog2(RATIO + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   fifo_empty,
   input  logic [WIDTH-1:0]       fifo_data_in,
   output logic                   fifo_read,
   input  logic                   flush,
   output logic                   flush_done,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH*RATIO-1:0] out_data,
   output logic [CW-1:0]          out_count
);

   localparam logic [1:0] ST_FILL       = 2'd0;
   localparam logic [1:0] ST_FLUSH_WAIT = 2'd1;
   localparam logic [1:0] ST_EMIT       = 2'd2;

   logic [1:0]             state;
   logic [CW-1:0]          asm_cnt;
   logic                   rd_pend;
   logic [WIDTH-1:0]       lanes [RATIO];
   logic [WIDTH*RATIO-1:0] lanes_flat;
   logic [CW:0]            inflight;
   logic                   asm_full;
   logic                   out_free;
   logic                   full_xfer;
   logic                   part_xfer;

   for (genvar g = 0; g < RATIO; g++) begin : g_flat
      assign lanes_flat[g*WIDTH +: WIDTH] = lanes[g];
   end

   // Words already captured plus the one still in flight; reads stop once a beat's worth is owed.
   assign inflight  = {1'b0, asm_cnt} + {{CW{1'b0}}, rd_pend};
   assign asm_full  = (asm_cnt == CW'(RATIO));
   assign out_free  = !out_valid || out_ready;
   // A full beat may leave in any state, so a flush that finds a full beat lets it go first.
   assign full_xfer = asm_full && out_free;
   assign part_xfer = (state == ST_EMIT) && out_free;
   assign fifo_read = !rst && !fifo_empty && (state == ST_FILL) && (inflight < (CW+1)'(RATIO));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_FILL;
         asm_cnt    <= '0;
         rd_pend    <= 1'b0;
         flush_done <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_count  <= '0;
         for (int i = 0; i < RATIO; i++) lanes[i] <= '0;
      end else begin
         rd_pend    <= fifo_read;
         flush_done <= 1'b0;

         // Capture never coincides with a transfer: a full beat has no read in flight,
         // and EMIT is only entered once the in-flight word has landed.
         if (full_xfer || part_xfer) begin
            out_valid <= 1'b1;
            out_data  <= lanes_flat;
            out_count <= asm_cnt;
            asm_cnt   <= '0;
            for (int i = 0; i < RATIO; i++) lanes[i] <= '0;
         end else begin
            if (out_ready) out_valid <= 1'b0;
            if (rd_pend) begin
               for (int i = 0; i < RATIO; i++) begin
                  if (asm_cnt == CW'(i)) lanes[i] <= fifo_data_in;
               end
               asm_cnt <= asm_cnt + CW'(1);
            end
         end

         case (state)
            ST_FILL: begin
               if (flush) state <= ST_FLUSH_WAIT;
            end
            ST_FLUSH_WAIT: begin
               if (!rd_pend) begin
                  if (asm_cnt == '0) begin
                     flush_done <= 1'b1;
                     state      <= ST_FILL;
                  end else if (!asm_full) begin
                     state <= ST_EMIT;
                  end
               end
            end
            ST_EMIT: begin
               if (out_free) begin
                  flush_done <= 1'b1;
                  state      <= ST_FILL;
               end
            end
            default: state <= ST_FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_pack_reader.sv
// Bench for fifo_pack_reader (WIDTH=16, RATIO=4): FIFO model + word-grouping reference + scoreboard.
module tb_fifo_pack_reader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fifo_empty = 1'b1;
   logic [15:0] fifo_data_in = '0;
   logic        fifo_read;
   logic        flush = 1'b0;
   logic        flush_done;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_data;
   logic [2:0]  out_count;

   fifo_pack_reader #(.WIDTH(16), .RATIO(4)) dut (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data_in(fifo_data_in),
      .fifo_read(fifo_read), .flush(flush), .flush_done(flush_done),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] data;
      logic [2:0]  cnt;
      logic        done;
   } beat_t;

   beat_t       exp_q[$];
   logic [15:0] fifo_q[$];
   logic [15:0] grp[$];
   int          errors = 0;
   int          checks = 0;
   int          exp_flushes = 0;
   int          act_done = 0;
   logic        rd_s = 1'b0;
   logic        fl_s = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: popped words form beats of four in pop order; a flush closes the open group.
   task automatic close_group(input logic done);
      beat_t b;
      b.data = '0;
      b.cnt  = 3'(grp.size());
      b.done = done;
      for (int i = 0; i < grp.size(); i++) b.data[i*16 +: 16] = grp[i];
      exp_q.push_back(b);
      grp.delete();
   endtask

   task automatic push_word(input logic [15:0] w);
      fifo_q.push_back(w);
      fifo_empty = 1'b0;
   endtask

   // FIFO model: a pop seen before the edge delivers its word just after that edge.
   always @(posedge clk) begin
      #1;
      if (rd_s && !rst && fifo_q.size() > 0) begin
         fifo_data_in = fifo_q.pop_front();
         grp.push_back(fifo_data_in);
         if (grp.size() == 4) close_group(1'b0);
         fifo_empty = (fifo_q.size() == 0);
      end
      if (fl_s && !rst) begin
         exp_flushes++;
         if (grp.size() > 0) close_group(1'b1);
      end
   end

   // Monitor: samples on the falling edge, checks hold stability and scoreboard on handshake.
   logic        prev_valid = 1'b0;
   logic        prev_ready = 1'b0;
   logic [63:0] prev_data  = '0;
   logic [2:0]  prev_count = '0;
   logic        cur_done   = 1'b0;

   always @(negedge clk) begin
      rd_s = fifo_read;
      fl_s = flush;
      if (rst) begin
         prev_valid = 1'b0;
         prev_ready = 1'b0;
      end else begin
         chk("read_while_empty", 64'(fifo_read & fifo_empty), 64'(0));
         if (flush_done) act_done++;
         if (prev_valid && !prev_ready) begin
            chk("hold_valid", 64'(out_valid), 64'(1));
            chk("hold_data", out_data, prev_data);
            chk("hold_count", 64'(out_count), 64'(prev_count));
         end
         if (out_valid && (!prev_valid || prev_ready)) cur_done = flush_done;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got %h count %0d, none expected", out_data, out_count);
            end else begin
               beat_t b;
               b = exp_q.pop_front();
               chk("beat_data", out_data, b.data);
               chk("beat_count", 64'(out_count), 64'(b.cnt));
               chk("beat_flush_done", 64'(cur_done), 64'(b.done));
            end
         end
         prev_valid = out_valid;
         prev_ready = out_ready;
         prev_data  = out_data;
         prev_count = out_count;
      end
   end

   task automatic drain(input int bound);
      int n = 0;
      while ((exp_q.size() != 0 || fifo_q.size() != 0 || grp.size() != 0) && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0 || fifo_q.size() != 0 || grp.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d beats and %0d words left after %0d cycles",
                  exp_q.size(), fifo_q.size(), bound);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_done(input int d0, input int bound);
      int n = 0;
      while (act_done == d0 && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (act_done == d0) begin
         checks++;
         errors++;
         $display("FAIL flush_done_timeout: no flush_done within %0d cycles", bound);
      end
   endtask

   task automatic do_flush(input int bound);
      int d0;
      d0 = act_done;
      @(posedge clk); #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      wait_done(d0, bound);
   endtask

   initial begin
      int d0;
      // Reset with a non-empty FIFO: no pops, all outputs low.
      for (int i = 1; i <= 8; i++) push_word(16'(i));
      repeat (3) @(negedge clk);
      chk("rst_fifo_read", 64'(fifo_read), 64'(0));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_data", out_data, 64'(0));
      chk("rst_out_count", 64'(out_count), 64'(0));
      chk("rst_flush_done", 64'(flush_done), 64'(0));

      // Pack 1..8 into two beats.
      @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
      drain(100);

      // Backpressure: first beat held, second assembled, reads stopped.
      @(posedge clk); #1 out_ready = 1'b0;
      for (int i = 9; i <= 20; i++) push_word(16'(i));
      repeat (30) @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'(1));
      chk("bp_fifo_read", 64'(fifo_read), 64'(0));
      chk("bp_fifo_left", 64'(fifo_q.size()), 64'(4));
      @(posedge clk); #1 out_ready = 1'b1;
      drain(100);

      // Partial beat by flush.
      @(posedge clk); #1 push_word(16'h000A); push_word(16'h000B); push_word(16'h000C);
      repeat (10) @(negedge clk);
      do_flush(50);
      drain(50);

      // Flush with nothing assembled: completion pulse only.
      @(posedge clk); #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk); chk("empty_flush_early", 64'(flush_done), 64'(0));
      @(negedge clk); chk("empty_flush_done", 64'(flush_done), 64'(1));
      @(negedge clk); chk("empty_flush_pulse", 64'(flush_done), 64'(0));

      // Flush in the same cycle as a pop: the word lands in the partial beat.
      d0 = act_done;
      @(posedge clk); #1 push_word(16'h00D1); flush = 1'b1;
      @(negedge clk); chk("inflight_read", 64'(fifo_read), 64'(1));
      @(posedge clk); #1 flush = 1'b0;
      wait_done(d0, 50);
      drain(50);

      // Asynchronous reset with two words assembled, then a clean beat.
      @(posedge clk); #1 push_word(16'h0011); push_word(16'h0022);
      repeat (6) @(negedge clk);
      #2 rst = 1'b1;
      fifo_q.delete();
      grp.delete();
      fifo_empty = 1'b1;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'(0));
      chk("arst_out_data", out_data, 64'(0));
      chk("arst_out_count", 64'(out_count), 64'(0));
      chk("arst_flush_done", 64'(flush_done), 64'(0));
      chk("arst_fifo_read", 64'(fifo_read), 64'(0));
      @(posedge clk); #1 rst = 1'b0;
      for (int i = 1; i <= 4; i++) push_word(16'(i));
      drain(100);

      // Randomised traffic with random backpressure and occasional flushes.
      for (int it = 0; it < 500; it++) begin
         @(posedge clk); #1;
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 2) == 0) push_word(16'($urandom));
         if (it % 41 == 40) begin
            out_ready = 1'b1;
            do_flush(100);
         end
      end
      @(posedge clk); #1 out_ready = 1'b1;
      do_flush(100);
      drain(400);
      chk("flush_done_total", 64'(act_done), 64'(exp_flushes));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
